uart_rx: RTL

//   Receive side of the UART link: recovers 8-bit frames from serial RX_IN and presents P_DATA

---
 rtl/uart_rx_pkg.sv | 24 ++
 rtl/uart_rx_sampler.sv | 46 ++++
 rtl/uart_rx.sv | 139 +++++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: FSM states, parity encoding, defaults.
package uart_rx_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned PRSC_WIDTH_DEF = 6;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  typedef enum logic {
    PAR_EVEN = 1'b0,
    PAR_ODD  = 1'b1
  } par_type_e;

  function automatic logic majority3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit edge counter and 3-sample majority vote around mid-bit.
module uart_rx_sampler
  import uart_rx_pkg::*;
#(
  parameter int unsigned PRSC_WIDTH = PRSC_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx,
  input  logic                  clear,
  input  logic [PRSC_WIDTH-1:0] prescale,
  output logic                  sampled_bit,
  output logic                  bit_done,
  output logic                  sample_rdy
);

  localparam logic [PRSC_WIDTH-1:0] ONE = PRSC_WIDTH'(1);
  localparam logic [PRSC_WIDTH-1:0] TWO = PRSC_WIDTH'(2);

  logic [PRSC_WIDTH-1:0] edge_cnt;
  logic [PRSC_WIDTH-1:0] half;
  logic [PRSC_WIDTH-1:0] last;
  logic [2:0]            samples;

  assign half = {1'b0, prescale[PRSC_WIDTH-1:1]};
  assign last = prescale - ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_cnt <= '0;
      samples  <= '1;
    end else if (clear) begin
      edge_cnt <= '0;
    end else begin
      edge_cnt <= (edge_cnt == last) ? '0 : edge_cnt + ONE;
      if (edge_cnt == half - ONE) samples[0] <= rx;
      if (edge_cnt == half)       samples[1] <= rx;
      if (edge_cnt == half + ONE) samples[2] <= rx;
    end
  end

  assign sampled_bit = majority3(samples);
  assign bit_done    = !clear && (edge_cnt == last);
  assign sample_rdy  = !clear && (edge_cnt == half + TWO);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronizer, frame FSM, shift register, parity/stop checks, output strobes.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned PRSC_WIDTH = PRSC_WIDTH_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [PRSC_WIDTH-1:0] PRESCALE,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  DATA_VALID,
  output logic                  PAR_ERR,
  output logic                  STP_ERR
);

  localparam int unsigned BW = $clog2(DATA_WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  rx_state_e state_q, state_d;

  logic                  rx_meta, rx_sync;
  logic [PRSC_WIDTH-1:0] prescale_q;
  logic                  par_en_q;
  par_type_e             par_typ_q;
  logic [DATA_WIDTH-1:0] shreg;
  logic [BW-1:0]         bit_cnt_q;
  logic                  par_flag;

  logic sampled_bit, bit_done, sample_rdy;
  logic start_frame, shift_en, par_chk, frame_end;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= RX_IN;
      rx_sync <= rx_meta;
    end
  end

  uart_rx_sampler #(
    .PRSC_WIDTH(PRSC_WIDTH)
  ) u_sampler (
    .clk        (CLK),
    .rst_n      (RST),
    .rx         (rx_sync),
    .clear      (state_q == ST_IDLE),
    .prescale   (prescale_q),
    .sampled_bit(sampled_bit),
    .bit_done   (bit_done),
    .sample_rdy (sample_rdy)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    start_frame = 1'b0;
    shift_en    = 1'b0;
    par_chk     = 1'b0;
    frame_end   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!rx_sync) begin
          state_d     = ST_START;
          start_frame = 1'b1;
        end
      end
      ST_START: begin
        if (sample_rdy && sampled_bit) state_d = ST_IDLE;
        else if (bit_done)             state_d = ST_DATA;
      end
      ST_DATA: begin
        shift_en = sample_rdy;
        if (bit_done && bit_cnt_q == LAST_BIT)
          state_d = par_en_q ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        par_chk = sample_rdy;
        if (bit_done) state_d = ST_STOP;
      end
      ST_STOP: begin
        // Leave at mid-stop so a back-to-back start edge is not missed.
        if (sample_rdy) begin
          frame_end = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      prescale_q <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= PAR_EVEN;
      shreg      <= '0;
      bit_cnt_q  <= '0;
      par_flag   <= 1'b0;
      P_DATA     <= '0;
      DATA_VALID <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;
    end else begin
      DATA_VALID <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;
      if (start_frame) begin
        prescale_q <= PRESCALE;
        par_en_q   <= PAR_EN;
        par_typ_q  <= par_type_e'(PAR_TYP);
        bit_cnt_q  <= '0;
        par_flag   <= 1'b0;
      end
      if (state_q == ST_DATA && bit_done) bit_cnt_q <= bit_cnt_q + 1'b1;
      if (shift_en) shreg <= {sampled_bit, shreg[DATA_WIDTH-1:1]};
      if (par_chk)
        par_flag <= sampled_bit != ((^shreg) ^ (par_typ_q == PAR_ODD));
      if (frame_end) begin
        PAR_ERR <= par_flag;
        STP_ERR <= ~sampled_bit;
        if (!par_flag && sampled_bit) begin
          DATA_VALID <= 1'b1;
          P_DATA     <= shreg;
        end
      end
    end
  end

endmodule
